// File: rtl/qpu_exu_oitf_pkg.sv
// Shared sizing defaults for the QPU outstanding instruction track FIFO.
// Optional qubit-flag tracking is enabled by defining QPU_OITF_QF_EN.
package qpu_exu_oitf_pkg;

    localparam int QPU_OITF_DEPTH       = 4;
    localparam int QPU_RFIDX_REAL_WIDTH = 5;
    localparam int QPU_QUBIT_NUM        = 8;

    // Pointer width for a power-of-two depth of at least 2.
    function automatic int oitf_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/qpu_exu_oitf_ptr.sv
// Circular-buffer pointer with wrap flag for the OITF.
// Macro QPU_OITF_QF_EN does not affect this block.
module qpu_oitf_ptr
    import qpu_exu_oitf_pkg::*;
#(
    parameter int DEPTH = QPU_OITF_DEPTH,
    parameter int PTR_W = oitf_ptr_w(QPU_OITF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr,
    output logic             o_flag
);

    logic [PTR_W-1:0] r_ptr;
    logic             r_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_flag <= 1'b0;
        end else if (i_inc) begin
            if (r_ptr == PTR_W'(DEPTH - 1)) begin
                r_ptr  <= '0;
                r_flag <= ~r_flag;
            end else begin
                r_ptr  <= r_ptr + 1'b1;
            end
        end
    end

    assign o_ptr  = r_ptr;
    assign o_flag = r_flag;

endmodule

// File: rtl/qpu_exu_oitf.sv
// Outstanding Instruction Track FIFO for the QPU execute stage.
// Define QPU_OITF_QF_EN to track qubit lists and flag qubit conflicts.
module qpu_exu_oitf
    import qpu_exu_oitf_pkg::*;
#(
    parameter int OITF_DEPTH = QPU_OITF_DEPTH,
    parameter int RFIDX_W    = QPU_RFIDX_REAL_WIDTH,
    parameter int QUBIT_NUM  = QPU_QUBIT_NUM,
    parameter int PTR_W      = oitf_ptr_w(OITF_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_oitf_ena,
    output logic                 disp_oitf_ready,
    input  logic                 disp_oitf_rs1en,
    input  logic                 disp_oitf_rs2en,
    input  logic                 disp_oitf_rdwen,
    input  logic                 disp_oitf_qfren,
    input  logic [RFIDX_W-1:0]   disp_oitf_rs1idx,
    input  logic [RFIDX_W-1:0]   disp_oitf_rs2idx,
    input  logic [RFIDX_W-1:0]   disp_oitf_rdidx,
    input  logic [QUBIT_NUM-1:0] disp_oitf_qubitlist,
    output logic                 oitfrd_match_disprs1,
    output logic                 oitfrd_match_disprs2,
    output logic                 oitfrd_match_disprd,
    output logic                 oitfqf_match_dispql,
    input  logic                 oitf_ret_ena,
    output logic                 oitf_ret_rdwen,
    output logic [RFIDX_W-1:0]   oitf_ret_rdidx,
    output logic [QUBIT_NUM-1:0] oitf_ret_qubitlist,
    output logic [PTR_W-1:0]     oitf_dis_ptr,
    output logic [PTR_W-1:0]     oitf_ret_ptr,
    output logic                 oitf_empty
);

    logic             w_dis_flag;
    logic             w_ret_flag;
    logic [PTR_W-1:0] w_dis_ptr;
    logic [PTR_W-1:0] w_ret_ptr;
    logic             w_ptr_eq;
    logic             w_full;
    logic             w_empty;
    logic             w_alc;
    logic             w_ret;

    logic               r_vld   [OITF_DEPTH];
    logic               r_rdwen [OITF_DEPTH];
    logic [RFIDX_W-1:0] r_rdidx [OITF_DEPTH];

    assign w_ptr_eq = (w_dis_ptr == w_ret_ptr);
    assign w_full   = w_ptr_eq & (w_dis_flag != w_ret_flag);
    assign w_empty  = w_ptr_eq & (w_dis_flag == w_ret_flag);
    assign w_alc    = disp_oitf_ena & ~w_full;
    assign w_ret    = oitf_ret_ena & ~w_empty;

    qpu_oitf_ptr #(
        .DEPTH (OITF_DEPTH),
        .PTR_W (PTR_W)
    ) u_dis_ptr (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_alc),
        .o_ptr  (w_dis_ptr),
        .o_flag (w_dis_flag)
    );

    qpu_oitf_ptr #(
        .DEPTH (OITF_DEPTH),
        .PTR_W (PTR_W)
    ) u_ret_ptr (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_ret),
        .o_ptr  (w_ret_ptr),
        .o_flag (w_ret_flag)
    );

    // Alloc and retire never share a slot: equal pointers mean full or empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                r_vld[i]   <= 1'b0;
                r_rdwen[i] <= 1'b0;
                r_rdidx[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (w_ret && (w_ret_ptr == PTR_W'(i))) begin
                    r_vld[i] <= 1'b0;
                end
                if (w_alc && (w_dis_ptr == PTR_W'(i))) begin
                    r_vld[i]   <= 1'b1;
                    r_rdwen[i] <= disp_oitf_rdwen;
                    r_rdidx[i] <= disp_oitf_rdidx;
                end
            end
        end
    end

    logic w_m_rs1;
    logic w_m_rs2;
    logic w_m_rd;

    always_comb begin
        w_m_rs1 = 1'b0;
        w_m_rs2 = 1'b0;
        w_m_rd  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (r_vld[i] && r_rdwen[i]) begin
                if (disp_oitf_rs1en && (r_rdidx[i] == disp_oitf_rs1idx))
                    w_m_rs1 = 1'b1;
                if (disp_oitf_rs2en && (r_rdidx[i] == disp_oitf_rs2idx))
                    w_m_rs2 = 1'b1;
                if (disp_oitf_rdwen && (r_rdidx[i] == disp_oitf_rdidx))
                    w_m_rd = 1'b1;
            end
        end
    end

`ifdef QPU_OITF_QF_EN
    logic                 r_qfren [OITF_DEPTH];
    logic [QUBIT_NUM-1:0] r_ql    [OITF_DEPTH];
    logic                 w_m_ql;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                r_qfren[i] <= 1'b0;
                r_ql[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (w_alc && (w_dis_ptr == PTR_W'(i))) begin
                    r_qfren[i] <= disp_oitf_qfren;
                    r_ql[i]    <= disp_oitf_qubitlist;
                end
            end
        end
    end

    always_comb begin
        w_m_ql = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (r_vld[i] && r_qfren[i] && |(r_ql[i] & disp_oitf_qubitlist))
                w_m_ql = 1'b1;
        end
    end

    assign oitfqf_match_dispql = disp_oitf_qfren & w_m_ql;
    assign oitf_ret_qubitlist  = w_empty ? '0 : r_ql[w_ret_ptr];
`else
    logic w_unused_qf;

    assign w_unused_qf         = disp_oitf_qfren ^ (^disp_oitf_qubitlist);
    assign oitfqf_match_dispql = 1'b0;
    assign oitf_ret_qubitlist  = '0;
`endif

    assign disp_oitf_ready      = ~w_full;
    assign oitf_empty           = w_empty;
    assign oitfrd_match_disprs1 = w_m_rs1;
    assign oitfrd_match_disprs2 = w_m_rs2;
    assign oitfrd_match_disprd  = w_m_rd;
    assign oitf_ret_rdwen       = w_empty ? 1'b0 : r_rdwen[w_ret_ptr];
    assign oitf_ret_rdidx       = w_empty ? '0 : r_rdidx[w_ret_ptr];
    assign oitf_dis_ptr         = w_dis_ptr;
    assign oitf_ret_ptr         = w_ret_ptr;

endmodule

// File: tb/tb_qpu_exu_oitf.sv
// Self-checking bench for qpu_exu_oitf: vector table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_qpu_exu_oitf;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_oitf_ena;
    logic       disp_oitf_ready;
    logic       disp_oitf_rs1en;
    logic       disp_oitf_rs2en;
    logic       disp_oitf_rdwen;
    logic       disp_oitf_qfren;
    logic [4:0] disp_oitf_rs1idx;
    logic [4:0] disp_oitf_rs2idx;
    logic [4:0] disp_oitf_rdidx;
    logic [7:0] disp_oitf_qubitlist;
    logic       oitfrd_match_disprs1;
    logic       oitfrd_match_disprs2;
    logic       oitfrd_match_disprd;
    logic       oitfqf_match_dispql;
    logic       oitf_ret_ena;
    logic       oitf_ret_rdwen;
    logic [4:0] oitf_ret_rdidx;
    logic [7:0] oitf_ret_qubitlist;
    logic [1:0] oitf_dis_ptr;
    logic [1:0] oitf_ret_ptr;
    logic       oitf_empty;

    qpu_exu_oitf dut (
        .clk                  (clk),
        .rst                  (rst),
        .disp_oitf_ena        (disp_oitf_ena),
        .disp_oitf_ready      (disp_oitf_ready),
        .disp_oitf_rs1en      (disp_oitf_rs1en),
        .disp_oitf_rs2en      (disp_oitf_rs2en),
        .disp_oitf_rdwen      (disp_oitf_rdwen),
        .disp_oitf_qfren      (disp_oitf_qfren),
        .disp_oitf_rs1idx     (disp_oitf_rs1idx),
        .disp_oitf_rs2idx     (disp_oitf_rs2idx),
        .disp_oitf_rdidx      (disp_oitf_rdidx),
        .disp_oitf_qubitlist  (disp_oitf_qubitlist),
        .oitfrd_match_disprs1 (oitfrd_match_disprs1),
        .oitfrd_match_disprs2 (oitfrd_match_disprs2),
        .oitfrd_match_disprd  (oitfrd_match_disprd),
        .oitfqf_match_dispql  (oitfqf_match_dispql),
        .oitf_ret_ena         (oitf_ret_ena),
        .oitf_ret_rdwen       (oitf_ret_rdwen),
        .oitf_ret_rdidx       (oitf_ret_rdidx),
        .oitf_ret_qubitlist   (oitf_ret_qubitlist),
        .oitf_dis_ptr         (oitf_dis_ptr),
        .oitf_ret_ptr         (oitf_ret_ptr),
        .oitf_empty           (oitf_empty)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the FIFO contents as a queue, pointers from totals.
    typedef struct {
        logic       wen;
        logic [4:0] idx;
        logic       qf;
        logic [7:0] ql;
    } ment_t;

    ment_t m_q[$];
    int    m_alc_cnt;
    int    m_ret_cnt;

    task automatic model_clear();
        m_q.delete();
        m_alc_cnt = 0;
        m_ret_cnt = 0;
    endtask

    task automatic check_model(string tag);
        logic       e_m1, e_m2, e_md, e_qf, e_hw;
        logic [4:0] e_hrd;
        logic [7:0] e_hql;
        e_m1 = 0; e_m2 = 0; e_md = 0; e_qf = 0;
        foreach (m_q[k]) begin
            if (m_q[k].wen && disp_oitf_rs1en && m_q[k].idx == disp_oitf_rs1idx)
                e_m1 = 1;
            if (m_q[k].wen && disp_oitf_rs2en && m_q[k].idx == disp_oitf_rs2idx)
                e_m2 = 1;
            if (m_q[k].wen && disp_oitf_rdwen && m_q[k].idx == disp_oitf_rdidx)
                e_md = 1;
            if (disp_oitf_qfren && m_q[k].qf && (m_q[k].ql & disp_oitf_qubitlist) != 0)
                e_qf = 1;
        end
        e_hw  = (m_q.size() == 0) ? 1'b0 : m_q[0].wen;
        e_hrd = (m_q.size() == 0) ? 5'd0 : m_q[0].idx;
        e_hql = (m_q.size() == 0) ? 8'd0 : m_q[0].ql;
`ifndef QPU_OITF_QF_EN
        e_qf  = 0;
        e_hql = 0;
`endif
        chk({tag, ".ready"}, disp_oitf_ready, m_q.size() != DEPTH);
        chk({tag, ".empty"}, oitf_empty, m_q.size() == 0);
        chk({tag, ".m_rs1"}, oitfrd_match_disprs1, e_m1);
        chk({tag, ".m_rs2"}, oitfrd_match_disprs2, e_m2);
        chk({tag, ".m_rd"}, oitfrd_match_disprd, e_md);
        chk({tag, ".m_ql"}, oitfqf_match_dispql, e_qf);
        chk({tag, ".h_wen"}, oitf_ret_rdwen, e_hw);
        chk({tag, ".h_rd"}, oitf_ret_rdidx, e_hrd);
        chk({tag, ".h_ql"}, oitf_ret_qubitlist, e_hql);
        chk({tag, ".dptr"}, oitf_dis_ptr, m_alc_cnt % DEPTH);
        chk({tag, ".rptr"}, oitf_ret_ptr, m_ret_cnt % DEPTH);
    endtask

    task automatic model_edge();
        ment_t e;
        logic  do_alc, do_ret;
        do_alc = disp_oitf_ena && (m_q.size() < DEPTH);
        do_ret = oitf_ret_ena && (m_q.size() > 0);
        if (do_ret) begin
            void'(m_q.pop_front());
            m_ret_cnt++;
        end
        if (do_alc) begin
            e.wen = disp_oitf_rdwen;
            e.idx = disp_oitf_rdidx;
            e.qf  = disp_oitf_qfren;
            e.ql  = disp_oitf_qubitlist;
            m_q.push_back(e);
            m_alc_cnt++;
        end
    endtask

    task automatic set_in(int ena, int ret, int r1e, int r1, int r2e,
                          int r2, int rde, int rd, int qf, int ql);
        disp_oitf_ena       = ena[0];
        oitf_ret_ena        = ret[0];
        disp_oitf_rs1en     = r1e[0];
        disp_oitf_rs1idx    = r1[4:0];
        disp_oitf_rs2en     = r2e[0];
        disp_oitf_rs2idx    = r2[4:0];
        disp_oitf_rdwen     = rde[0];
        disp_oitf_rdidx     = rd[4:0];
        disp_oitf_qfren     = qf[0];
        disp_oitf_qubitlist = ql[7:0];
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic mstep(string tag);
        #1;
        check_model(tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        logic       ena, ret, r1e;
        logic [4:0] r1;
        logic       r2e;
        logic [4:0] r2;
        logic       rde;
        logic [4:0] rd;
        logic       rdy, emp, m1, m2, md;
        logic [1:0] dp, rp;
        logic [4:0] hrd;
    } vec_t;

    function automatic vec_t mk(int ena, int ret, int r1e, int r1, int r2e,
                                int r2, int rde, int rd, int rdy, int emp,
                                int m1, int m2, int md, int dp, int rp,
                                int hrd);
        vec_t v;
        v.ena = ena[0]; v.ret = ret[0]; v.r1e = r1e[0]; v.r1 = r1[4:0];
        v.r2e = r2e[0]; v.r2 = r2[4:0]; v.rde = rde[0]; v.rd = rd[4:0];
        v.rdy = rdy[0]; v.emp = emp[0]; v.m1 = m1[0]; v.m2 = m2[0];
        v.md = md[0]; v.dp = dp[1:0]; v.rp = rp[1:0]; v.hrd = hrd[4:0];
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        //               ena ret r1e r1 r2e r2 rde rd  rdy emp m1 m2 md dp rp hrd
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 1, 3,  1, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 3, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 0, 3);
        tbl[3]  = mk(0, 0, 1, 3, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1, 4,  1, 1, 0, 0, 0, 1, 1, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1, 5,  1, 0, 0, 0, 0, 2, 1, 4);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 6,  1, 0, 0, 0, 0, 3, 1, 4);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1, 7,  1, 0, 0, 0, 0, 0, 1, 4);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 1, 5,  0, 0, 0, 0, 1, 1, 1, 4);
        tbl[9]  = mk(0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 0, 1, 0, 1, 1, 4);
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 4);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 9,  1, 0, 0, 0, 0, 1, 2, 5);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 2, 5);
        tbl[13] = mk(0, 0, 1, 4, 1, 9, 0, 0,  0, 0, 0, 1, 0, 2, 2, 5);

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        @(negedge clk);
        #1;
        check_model("rst");
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            set_in(tbl[i].ena, tbl[i].ret, tbl[i].r1e, tbl[i].r1,
                   tbl[i].r2e, tbl[i].r2, tbl[i].rde, tbl[i].rd, 0, 0);
            #1;
            chk($sformatf("t%0d.ready", i), disp_oitf_ready, tbl[i].rdy);
            chk($sformatf("t%0d.empty", i), oitf_empty, tbl[i].emp);
            chk($sformatf("t%0d.m_rs1", i), oitfrd_match_disprs1, tbl[i].m1);
            chk($sformatf("t%0d.m_rs2", i), oitfrd_match_disprs2, tbl[i].m2);
            chk($sformatf("t%0d.m_rd", i), oitfrd_match_disprd, tbl[i].md);
            chk($sformatf("t%0d.dptr", i), oitf_dis_ptr, tbl[i].dp);
            chk($sformatf("t%0d.rptr", i), oitf_ret_ptr, tbl[i].rp);
            chk($sformatf("t%0d.h_rd", i), oitf_ret_rdidx, tbl[i].hrd);
            @(posedge clk);
            @(negedge clk);
        end

        // Steady two-entry occupancy with concurrent alloc and retire.
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        mstep("fill0");
        set_in(1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        mstep("fill1");
        for (int k = 0; k < 10; k++) begin
            set_in(1, 1, 1, 9 + k, 0, 0, 1, 10 + k, 0, 0);
            mstep($sformatf("ar%0d", k));
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ar.dptr", oitf_dis_ptr, 0);
        chk("ar.rptr", oitf_ret_ptr, 2);
        chk("ar.head", oitf_ret_rdidx, 18);
        chk("ar.ready", disp_oitf_ready, 1);
        @(negedge clk);

        // Qubit-list conflict detection.
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0000_0110);
        mstep("qf_alc");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0000_0100);
        #1;
`ifdef QPU_OITF_QF_EN
        chk("qf.hit", oitfqf_match_dispql, 1);
`else
        chk("qf.hit", oitfqf_match_dispql, 0);
`endif
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1000_0000);
        #1;
        chk("qf.miss", oitfqf_match_dispql, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0000_0010);
        mstep("qf_model");

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom_range(0, 9) < 6) ? 1 : 0,
                   ($urandom_range(0, 9) < 5) ? 1 : 0,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)),
                   int'(($urandom & $urandom) & 32'hff));
            mstep($sformatf("rnd%0d", k));
        end

        // Reset with three entries outstanding.
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 1, 3, 1, 8'hff);
        mstep("rs_a0");
        set_in(1, 0, 0, 0, 0, 0, 1, 4, 1, 8'hff);
        mstep("rs_a1");
        set_in(1, 0, 0, 0, 0, 0, 1, 5, 1, 8'hff);
        mstep("rs_a2");
        set_in(0, 0, 1, 3, 1, 5, 1, 4, 1, 8'hff);
        #1;
        check_model("rs_pre");
        rst = 1'b1;
        #1;
        chk("rs.empty", oitf_empty, 1);
        chk("rs.m_rs1", oitfrd_match_disprs1, 0);
        chk("rs.m_rs2", oitfrd_match_disprs2, 0);
        chk("rs.m_rd", oitfrd_match_disprd, 0);
        chk("rs.m_ql", oitfqf_match_dispql, 0);
        chk("rs.h_wen", oitf_ret_rdwen, 0);
        chk("rs.h_rd", oitf_ret_rdidx, 0);
        chk("rs.ready", disp_oitf_ready, 1);
        chk("rs.dptr", oitf_dis_ptr, 0);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        mstep("rs_post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/qpu_exu_oitf.md
# qpu_exu_oitf

Outstanding Instruction Track FIFO for the QPU execute stage: the receiving end of the dispatch-to-OITF interface. Each long-pipe instruction dispatched into the ALU allocates an entry recording its destination register and measured/flagged qubit list. Long-pipe write-back retires entries in order. Combinational match outputs let dispatch stall on RAW/WAW register hazards and on qubit-flag conflicts.

## Interface
Parameters:
- OITF_DEPTH, `QPU_OITF_DEPTH` (4): entries; power of two, at least 2.
- RFIDX_W, `QPU_RFIDX_REAL_WIDTH` (5): register index width.
- QUBIT_NUM, `QPU_QUBIT_NUM` (8): qubit list width.
- PTR_W, log2(OITF_DEPTH): pointer width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- disp_oitf_ena  in  1  allocate one entry this cycle.
- disp_oitf_ready  out  1  FIFO not full.
- disp_oitf_rs1en / disp_oitf_rs2en / disp_oitf_rdwen / disp_oitf_qfren  in  1 each  operand enables of the dispatching instruction.
- disp_oitf_rs1idx / disp_oitf_rs2idx / disp_oitf_rdidx  in  RFIDX_W each  operand indices.
- disp_oitf_qubitlist  in  QUBIT_NUM  qubits touched by the dispatching measure or FMR.
- oitfrd_match_disprs1 / oitfrd_match_disprs2 / oitfrd_match_disprd  out  1 each  hazard matches.
- oitfqf_match_dispql  out  1  qubit-list conflict.
- oitf_ret_ena  in  1  retire the oldest entry.
- oitf_ret_rdwen  out  1  rdwen of the head entry.
- oitf_ret_rdidx  out  RFIDX_W  rdidx of the head entry.
- oitf_ret_qubitlist  out  QUBIT_NUM  qubit list of the head entry.
- oitf_dis_ptr / oitf_ret_ptr  out  PTR_W  allocate and retire pointers.
- oitf_empty  out  1  no valid entries.

## Operation
- Storage is a circular buffer. Each entry holds valid, rdwen, rdidx, qfren and qubitlist.
- There is one allocate pointer and one retire pointer, each with a wrap flag.
- empty = pointers equal and flags equal; full = pointers equal and flags differ.
- disp_oitf_ready = !full.
- Allocate: on disp_oitf_ena & !full, write the entry at the allocate pointer, set valid, advance the pointer. A full FIFO ignores disp_oitf_ena and does not corrupt state.
- Retire: on oitf_ret_ena & !empty, clear valid at the retire pointer and advance it. oitf_ret_ena while empty is ignored.
- Allocate and retire in the same cycle both take effect. Count is unchanged. With DEPTH=1-occupancy, no overlap hazard arises because the two pointers differ.
- When full, the same-cycle retire does not enable an allocate; disp_oitf_ready is registered-state based only.
- Pointer wrap: at DEPTH-1 the pointer advances to 0 and toggles its flag.
- Register matches are the OR over valid entries:
  - rs1 match: entry.rdwen & disp_oitf_rs1en & entry.rdidx == disp_oitf_rs1idx.
  - rs2 and rd: same form, using rs2en and rdwen.
- oitfqf_match_dispql = disp_oitf_qfren & OR over valid entries of (entry.qfren & |(entry.qubitlist & disp_oitf_qubitlist)).
- Register index 0 gets no special treatment; dispatch gates x0 through the enables.
- Head outputs show the retire-pointer entry combinationally. They are meaningful only when !oitf_empty and are zero when empty.

## Timing
- Reset values (asynchronous): pointers 0, wrap flags 0, all valid 0. Outputs: disp_oitf_ready=1, oitf_empty=1, all match outputs 0, head outputs 0, pointers 0.
- Match, ready, empty and head outputs are combinational from registered state plus the dispatch inputs. An entry allocated at edge N is visible to matches from cycle N+1.
- An entry retired at edge N stops matching from cycle N+1. There is no same-cycle bypass of retire into the match outputs.
- Asserting rst mid-operation discards all entries immediately. No retire notification is produced for discarded entries.

## Configuration
- QPU_OITF_QF_EN defined: qfren and qubitlist are stored and oitfqf_match_dispql is computed as above.
- QPU_OITF_QF_EN undefined:
  - qubit fields are not stored;
  - oitfqf_match_dispql is tied to 0;
  - oitf_ret_qubitlist is tied to 0;
  - disp_oitf_qfren and disp_oitf_qubitlist are unused.

## Structure
- QPU_defines.v holds QPU_OITF_DEPTH, QPU_RFIDX_REAL_WIDTH and QPU_QUBIT_NUM, and gains QPU_OITF_QF_EN.
- Sub-module qpu_oitf_ptr: a PTR_W pointer plus wrap flag with an increment enable and asynchronous reset. It is instantiated twice, once for allocate and once for retire.

## Test plan
- Reset, then idle: disp_oitf_ready=1, oitf_empty=1, all matches 0, both pointers 0.
- Allocate rdwen=1, rdidx=3. Next cycle, dispatch rs1en=1, rs1idx=3 -> oitfrd_match_disprs1=1. Retire it -> the match is 0 the cycle after the retire edge.
- Allocate 4 entries (DEPTH=4) -> disp_oitf_ready=0. A fifth disp_oitf_ena is ignored. Retire one, then allocate one -> oitf_dis_ptr=1 with its flag set.
- Simultaneous allocate and retire at 2 entries for 10 cycles -> count stays 2, both pointers wrap, and head outputs track order.
- With QF_EN defined: allocate qfren=1, qubitlist=8'b0000_0110. Dispatch qfren=1, qubitlist=8'b0000_0100 -> oitfqf_match_dispql=1. Dispatch qubitlist 8'b1000_0000 -> 0. With QF_EN undefined, the output is always 0.
- Assert rst with 3 entries outstanding -> oitf_empty=1 and matches 0 immediately, with no retire outputs.
